mpe_skew_feeder: RTL and testbench

//  Upstream stage of the MPE 9x1 PE column. Loads one weight vector, then streams fmap vectors

---
 rtl/mpe_feeder_pkg.sv | 16 +
 rtl/skew_delay_line.sv | 37 +++
 rtl/mpe_skew_feeder.sv | 139 +++++++++++++
 tb/tb_mpe_skew_feeder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpe_feeder_pkg.sv
// Shared state encoding and default sizing for the MPE skew feeder.
package mpe_feeder_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUMBER_PE  = 9;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage {valid,data} shift register for one fmap lane.
// Data is zeroed on entry whenever valid is low, so empty slots always carry 0.
module skew_delay_line #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift_valid,
  input  logic [DATA_WIDTH-1:0] shift_data,
  output logic                  tap_valid,
  output logic [DATA_WIDTH-1:0] tap_data
);

  logic                  vld_q [DEPTH];
  logic [DATA_WIDTH-1:0] dat_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= shift_valid;
      dat_q[0] <= shift_valid ? shift_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign tap_valid = vld_q[DEPTH-1];
  assign tap_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/mpe_skew_feeder.sv
// Feeds one weight vector and then a diagonally skewed fmap stream into the MPE PE column.
// Lane k of each accepted fmap vector appears k cycles after lane 0.
module mpe_skew_feeder
  import mpe_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUMBER_PE  = DEF_NUMBER_PE,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                            i_clk,
  input  logic                            i_rest_n,
  input  logic                            i_start,
  input  logic [CNT_WIDTH-1:0]            i_num_vec,
  input  logic                            i_w_valid,
  input  logic [NUMBER_PE*DATA_WIDTH-1:0] i_w_data,
  output logic                            o_w_ready,
  input  logic                            i_f_valid,
  input  logic [NUMBER_PE*DATA_WIDTH-1:0] i_f_data,
  output logic                            o_f_ready,
  output logic                            o_weight_en,
  output logic [NUMBER_PE*DATA_WIDTH-1:0] o_weight_f_top,
  output logic [NUMBER_PE-1:0]            o_left_en,
  output logic [NUMBER_PE-1:0]            o_right_en,
  output logic [NUMBER_PE*DATA_WIDTH-1:0] o_fmap_f_left,
  output logic                            o_busy,
  output logic                            o_done
);

  localparam int DRAIN_W = $clog2(NUMBER_PE + 1);

  state_t                            state;
  state_t                            state_nxt;
  logic [CNT_WIDTH-1:0]              num_vec_q;
  logic [CNT_WIDTH-1:0]              acc_cnt;
  logic [DRAIN_W-1:0]                drain_cnt;
  logic                              start_accept;
  logic                              w_accept;
  logic                              f_accept;
  logic                              weight_en_q;
  logic [NUMBER_PE*DATA_WIDTH-1:0]   weight_q;
  logic [NUMBER_PE-1:0]              lane_en;

  assign start_accept = (state == IDLE) && i_start;
  assign w_accept     = i_w_valid && o_w_ready;
  assign f_accept     = i_f_valid && o_f_ready;

  always_ff @(posedge i_clk or negedge i_rest_n) begin
    if (!i_rest_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // STREAM lingers one cycle after the final accept so the last vector is already in the lanes
  // when DRAIN starts counting; DRAIN then lasts exactly NUMBER_PE cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = LOAD_W;
      LOAD_W:  if (w_accept) state_nxt = (num_vec_q == '0) ? DONE : STREAM;
      STREAM:  if (acc_cnt == num_vec_q) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_W'(NUMBER_PE - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_w_ready = 1'b0;
    o_f_ready = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      IDLE:    ;
      LOAD_W:  begin o_w_ready = 1'b1; o_busy = 1'b1; end
      STREAM:  begin o_f_ready = (acc_cnt < num_vec_q); o_busy = 1'b1; end
      DRAIN:   o_busy = 1'b1;
      DONE:    begin o_done = 1'b1; o_busy = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rest_n) begin
    if (!i_rest_n) begin
      num_vec_q <= '0;
      acc_cnt   <= '0;
    end else if (start_accept) begin
      num_vec_q <= i_num_vec;
      acc_cnt   <= '0;
    end else if (f_accept) begin
      acc_cnt   <= acc_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rest_n) begin
    if (!i_rest_n) begin
      drain_cnt <= '0;
    end else if (state == DRAIN) begin
      drain_cnt <= drain_cnt + DRAIN_W'(1);
    end else begin
      drain_cnt <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rest_n) begin
    if (!i_rest_n) begin
      weight_q    <= '0;
      weight_en_q <= 1'b0;
    end else begin
      weight_en_q <= w_accept;
      if (w_accept) begin
        weight_q <= i_w_data;
      end
    end
  end

  assign o_weight_en    = weight_en_q;
  assign o_weight_f_top = weight_q;

  // Lane k uses k+1 stages so an accept at edge t reaches the lane output after edge t+k.
  for (genvar k = 0; k < NUMBER_PE; k++) begin : g_lane
    skew_delay_line #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (k + 1)
    ) u_delay (
      .clk         (i_clk),
      .rst_n       (i_rest_n),
      .shift_valid (f_accept),
      .shift_data  (i_f_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .tap_valid   (lane_en[k]),
      .tap_data    (o_fmap_f_left[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign o_left_en  = lane_en;
  assign o_right_en = lane_en;

endmodule

// File: tb/tb_mpe_skew_feeder.sv
// Scoreboard bench for mpe_skew_feeder: the job driver predicts every lane slot, weight pulse and
// done pulse by cycle number; a negedge monitor pops and compares whatever is due that cycle.
module tb_mpe_skew_feeder;

  localparam int DW  = 32;
  localparam int NPE = 9;
  localparam int CW  = 16;
  localparam int VW  = NPE * DW;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } lane_item_t;

  typedef struct {
    int            due;
    logic [VW-1:0] data;
  } w_item_t;

  logic           i_clk;
  logic           i_rest_n;
  logic           i_start;
  logic [CW-1:0]  i_num_vec;
  logic           i_w_valid;
  logic [VW-1:0]  i_w_data;
  logic           o_w_ready;
  logic           i_f_valid;
  logic [VW-1:0]  i_f_data;
  logic           o_f_ready;
  logic           o_weight_en;
  logic [VW-1:0]  o_weight_f_top;
  logic [NPE-1:0] o_left_en;
  logic [NPE-1:0] o_right_en;
  logic [VW-1:0]  o_fmap_f_left;
  logic           o_busy;
  logic           o_done;

  mpe_skew_feeder #(
    .DATA_WIDTH (DW),
    .NUMBER_PE  (NPE),
    .CNT_WIDTH  (CW)
  ) dut (
    .i_clk          (i_clk),
    .i_rest_n       (i_rest_n),
    .i_start        (i_start),
    .i_num_vec      (i_num_vec),
    .i_w_valid      (i_w_valid),
    .i_w_data       (i_w_data),
    .o_w_ready      (o_w_ready),
    .i_f_valid      (i_f_valid),
    .i_f_data       (i_f_data),
    .o_f_ready      (o_f_ready),
    .o_weight_en    (o_weight_en),
    .o_weight_f_top (o_weight_f_top),
    .o_left_en      (o_left_en),
    .o_right_en     (o_right_en),
    .o_fmap_f_left  (o_fmap_f_left),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int edge_cnt = 0;
  always @(posedge i_clk) edge_cnt <= edge_cnt + 1;

  int            n_checks = 0;
  int            n_fail   = 0;
  bit            mon_en   = 0;
  bit            m_busy   = 0;
  bit            m_w_ready = 0;
  bit            m_f_ready = 0;
  logic [VW-1:0] m_weight = '0;
  lane_item_t    lane_q [NPE][$];
  w_item_t       w_q [$];
  int            done_q [$];

  task automatic checkOutput(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] randVec();
    logic [VW-1:0] v;
    for (int i = 0; i < NPE; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  task automatic clearModel();
    for (int k = 0; k < NPE; k++) lane_q[k].delete();
    w_q.delete();
    done_q.delete();
    m_busy = 0; m_w_ready = 0; m_f_ready = 0; m_weight = '0;
  endtask

  task automatic stepCycle();
    @(posedge i_clk); #1;
    i_start = 0; i_w_valid = 0; i_f_valid = 0;
  endtask

  // Runs one job. reset_after > 0 fires an async reset once that many vectors are accepted.
  task automatic applyStimulus(input int n, input logic [VW-1:0] w, input int w_delay,
                               input int bubble_pct, input bit directed, input bit gap_once,
                               input bit noise, input int reset_after);
    int            acc;
    int            last;
    int            e;
    bit            v;
    bit            gap_done;
    logic [VW-1:0] f;
    lane_item_t    li;
    w_item_t       wi;

    i_start = 1; i_num_vec = CW'(n);
    stepCycle();
    i_num_vec = CW'($urandom);
    m_busy = 1; m_w_ready = 1;
    repeat (w_delay) stepCycle();
    i_w_valid = 1; i_w_data = w;
    stepCycle();
    e = edge_cnt;
    m_w_ready = 0; m_weight = w;
    wi.due = e; wi.data = w; w_q.push_back(wi);
    if (n == 0) begin
      done_q.push_back(e);
      stepCycle();
      m_busy = 0;
      return;
    end
    m_f_ready = 1; acc = 0; last = e; gap_done = 0;
    while (acc < n) begin
      v = ($urandom_range(99) >= bubble_pct);
      if (gap_once && acc == 1 && !gap_done) begin
        v = 0; gap_done = 1;
      end
      f = randVec();
      if (directed && acc == 0) f[DW-1:0] = 32'hBD01D614;
      if (directed && acc == 1) f[DW-1:0] = 32'hBD5C1B3D;
      i_f_valid = v; i_f_data = f;
      if (noise) begin
        i_start = ($urandom_range(3) == 0); i_num_vec = CW'($urandom);
        i_w_valid = 1'($urandom_range(1)); i_w_data = randVec();
      end
      stepCycle();
      if (v) begin
        e = edge_cnt;
        for (int k = 0; k < NPE; k++) begin
          li.due = e + k; li.data = f[k*DW +: DW];
          lane_q[k].push_back(li);
        end
        acc++; last = e;
      end
      if (acc == n) m_f_ready = 0;
      if (reset_after > 0 && acc == reset_after) begin
        checkOutput("four_lanes_active", o_left_en, VW'(9'b000001111));
        #2 i_rest_n = 0;
        #1;
        checkOutput("rst_left_en", o_left_en, '0);
        checkOutput("rst_right_en", o_right_en, '0);
        checkOutput("rst_busy", o_busy, '0);
        checkOutput("rst_fmap", o_fmap_f_left, '0);
        checkOutput("rst_weight_top", o_weight_f_top, '0);
        clearModel();
        @(negedge i_clk); #2;
        i_rest_n = 1;
        stepCycle();
        return;
      end
    end
    done_q.push_back(last + NPE + 1);
    while (edge_cnt < last + NPE + 1) begin
      if (noise) begin
        i_f_valid = 1; i_f_data = randVec();
        i_start = ($urandom_range(1) == 0); i_num_vec = CW'($urandom);
        i_w_valid = 1'($urandom_range(1)); i_w_data = randVec();
      end
      stepCycle();
    end
    stepCycle();
    m_busy = 0;
  endtask

  task automatic idleNoise(input int cycles);
    repeat (cycles) begin
      i_f_valid = 1; i_f_data = randVec();
      i_w_valid = 1; i_w_data = randVec();
      stepCycle();
    end
  endtask

  always @(negedge i_clk) begin
    logic [NPE-1:0] exp_en;
    logic [VW-1:0]  exp_data;
    logic           exp_wen;
    logic           exp_done;
    if (mon_en && i_rest_n) begin
      exp_en = '0; exp_data = '0;
      for (int k = 0; k < NPE; k++) begin
        if (lane_q[k].size() > 0 && lane_q[k][0].due == edge_cnt) begin
          exp_en[k] = 1'b1;
          exp_data[k*DW +: DW] = lane_q[k][0].data;
          void'(lane_q[k].pop_front());
        end
      end
      checkOutput("left_en", o_left_en, exp_en);
      checkOutput("right_en", o_right_en, exp_en);
      checkOutput("fmap_left", o_fmap_f_left, exp_data);
      exp_wen = (w_q.size() > 0 && w_q[0].due == edge_cnt);
      checkOutput("weight_en", o_weight_en, exp_wen);
      if (exp_wen) begin
        checkOutput("weight_at_pulse", o_weight_f_top, w_q[0].data);
        void'(w_q.pop_front());
      end
      checkOutput("weight_top", o_weight_f_top, m_weight);
      exp_done = (done_q.size() > 0 && done_q[0] == edge_cnt);
      if (exp_done) void'(done_q.pop_front());
      checkOutput("done", o_done, exp_done);
      checkOutput("busy", o_busy, m_busy);
      checkOutput("w_ready", o_w_ready, m_w_ready);
      checkOutput("f_ready", o_f_ready, m_f_ready);
    end
  end

  initial begin
    logic [VW-1:0] w1;
    int            pending;

    i_rest_n = 0; i_start = 0; i_num_vec = '0;
    i_w_valid = 0; i_w_data = '0; i_f_valid = 0; i_f_data = '0;
    #3;
    checkOutput("reset_left_en", o_left_en, '0);
    checkOutput("reset_fmap", o_fmap_f_left, '0);
    checkOutput("reset_busy", o_busy, '0);
    checkOutput("reset_done", o_done, '0);
    checkOutput("reset_weight_en", o_weight_en, '0);
    checkOutput("reset_weight_top", o_weight_f_top, '0);
    checkOutput("reset_ready", {o_w_ready, o_f_ready}, '0);
    #9 i_rest_n = 1;
    mon_en = 1;
    stepCycle();

    w1 = randVec();
    w1[0*DW +: DW] = 32'hBDAC8916;
    w1[3*DW +: DW] = 32'h3E0D4FFB;
    applyStimulus(2, w1, 1, 0, 0, 0, 0, 0);
    applyStimulus(2, randVec(), 0, 0, 1, 0, 0, 0);
    applyStimulus(3, randVec(), 0, 0, 0, 1, 0, 0);
    applyStimulus(0, randVec(), 2, 0, 0, 0, 0, 0);
    idleNoise(4);
    applyStimulus(20, randVec(), 0, 0, 0, 0, 0, 4);
    applyStimulus(5, randVec(), 0, 20, 0, 0, 1, 0);
    idleNoise(3);
    for (int j = 0; j < 8; j++) begin
      applyStimulus($urandom_range(1, 12), randVec(), $urandom_range(0, 3), 30, 0, 0, 1, 0);
      idleNoise(2);
    end
    repeat (3) stepCycle();

    pending = w_q.size() + done_q.size();
    for (int k = 0; k < NPE; k++) pending += lane_q[k].size();
    checkOutput("pending_expectations", VW'(pending), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
